uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter that shares one `uart_tx` serializer among `NREQ` byte producers (console, debug, telemetry). It accepts bytes over per-requester valid/ready handshakes and issues one `tx_start` pulse per byte. It waits for the serializer's done tick before issuing the next byte. A requester can hold the grant across a multi-byte packet using `req_last`, bounded by a hold timeout.

## Interface
- `NREQ`, default 4: number of requesters, range 2–8.
- `DBIT`, default 8: data bits per byte; must match `uart_tx`.
- `HOLD_TO`, default 1024: clock cycles a locked requester may idle between packet bytes before it loses the grant.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester byte valid.
- `req_last`  in  NREQ  qualifies the byte as the final byte of its packet.
- `req_data`  in  NREQ*DBIT  byte of requester i at bits [i*DBIT +: DBIT].
- `req_ready`  out  NREQ  byte accepted when `req_valid[i] & req_ready[i]` at a rising edge.
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_din`  out  DBIT  byte to serialize; stable from `tx_start` until the next accept.
- `tx_done_tick`  in  1  serializer stop-bit-complete pulse.
- `grant`  out  NREQ  one-hot owner; all zero when idle.
- `busy`  out  1  high in every state except IDLE.
- `timeout_pulse`  out  1  one-cycle pulse when a hold expires.

## Operation
- States: IDLE, START, SEND, HOLD.
- **IDLE**
  - Winner w = first i with `req_valid[i]`, searching upward from `rr_ptr` modulo NREQ.
  - `req_ready[w]` is asserted combinationally.
  - At the edge: `grant` <= onehot(w), `tx_din` <= `req_data[w]`, `last_r` <= `req_last[w]`, then go to START.
- **START**: `tx_start` = 1 for exactly this cycle, then go to SEND.
- **SEND**: wait for `tx_done_tick`.
  - If `last_r` = 1: go to IDLE, clear `grant`, `rr_ptr` <= (g+1) mod NREQ.
  - Otherwise: go to HOLD, `hold_cnt` <= 0.
- **HOLD**: `req_ready[g]` = 1; all other ready bits are 0.
  - If `req_valid[g]`: capture data and last, go to START.
  - Else if `hold_cnt` == HOLD_TO-1: go to IDLE, pulse `timeout_pulse`, clear `grant`, advance `rr_ptr` as above.
  - Else: `hold_cnt` increments.
- `req_ready` is 0 in START and SEND; at most one bit is set in any cycle.
- `tx_done_tick` outside SEND is ignored.
- `rr_ptr` width is clog2(NREQ); it wraps via explicit modulo, which covers non-power-of-two NREQ.
- `hold_cnt` width is clog2(HOLD_TO); it saturation-compares, no wrap.
- A non-last byte that arrives in HOLD on the same cycle as the timeout is accepted; the timeout does not fire.

## Timing
- Reset values: state IDLE, `grant` 0, `rr_ptr` 0, `tx_start` 0, `tx_din` 0, `timeout_pulse` 0, `busy` 0, `req_ready` 0 unless a valid is present.
- Accept at edge k → `tx_start` high during cycle k+1 → SEND from edge k+1.
- `tx_done_tick` at edge d:
  - Last byte: back in IDLE at d; the next accept can occur at edge d+1.
  - Locked packet: the HOLD accept can occur at edge d+1.
- Reset asserted mid-byte clears everything immediately. The serializer shares this reset, so no partial-byte state survives.

## Structure
- Shared package `uart_pkg`:
  - `uart_arb_state_t` enum.
  - Default DBIT constant.
  - Requester-index helper function `rr_next(ptr, n)`.
- Sub-module `uart_rr_pick`: combinational round-robin priority encoder. Inputs are the `req_valid` vector and `rr_ptr`; outputs are the winner index and `any_valid`.

## Test plan
- Single request: req 1 sends 0xA5, last = 1 → `req_ready[1]` for 1 cycle, `tx_start` next cycle, `tx_din` = 0xA5, `grant` = 0010 until done, then IDLE.
- Contention: all four valid with last = 1, `rr_ptr` = 0 → service order 0, 1, 2, 3, 0; `tx_start` count equals `tx_done_tick` count.
- Packet lock: req 2 sends 0x10, 0x20, 0x30 (last on 0x30) while req 0 is valid → all three bytes go out before any req 0 byte; `grant` stays 0100.
- Hold timeout, HOLD_TO = 8: req 3 sends a non-last byte then deasserts → `timeout_pulse` exactly 8 cycles after entering HOLD; `grant` cleared; next winner is req 0.
- Reset mid-SEND: `rst_n` low for 1 cycle → all outputs return to reset values at once; a late `tx_done_tick` afterward is ignored.
- Spurious `tx_done_tick` in IDLE and HOLD → no state change, no `tx_start`.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, defaults and round-robin helper for the UART transmit arbiter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, SEND, HOLD} uart_arb_state_t;
  localparam int DBIT_DEF = 8;
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1) % n;
  endfunction
endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester handshakes plus serializer control bundled for the arbiter
import uart_pkg::*;
interface uart_tx_arb_if #(parameter int NREQ = 4, parameter int DBIT = DBIT_DEF);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_last;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic tx_start;
  logic [DBIT-1:0] tx_din;
  logic tx_done_tick;
  logic [NREQ-1:0] grant;
  logic busy;
  logic timeout_pulse;
  modport master (
    output req_valid, req_last, req_data, tx_done_tick,
    input  req_ready, tx_start, tx_din, grant, busy, timeout_pulse
  );
  modport slave (
    input  req_valid, req_last, req_data, tx_done_tick,
    output req_ready, tx_start, tx_din, grant, busy, timeout_pulse
  );
endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: first valid requester at or above ptr, wrapping modulo NREQ
module uart_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            any_valid
);
  always_comb begin
    win = '0;
    any_valid = |valid;
    // scan from farthest to nearest so the closest valid index wins
    for (int k = NREQ - 1; k >= 0; k--)
      if (valid[(int'(ptr) + k) % NREQ]) win = PW'((int'(ptr) + k) % NREQ);
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin sharing of one uart_tx among NREQ producers with packet lock and hold timeout
import uart_pkg::*;
module uart_tx_arb #(
  parameter int NREQ = 4,
  parameter int DBIT = DBIT_DEF,
  parameter int HOLD_TO = 1024
) (
  input logic clk,
  input logic rst_n,
  uart_tx_arb_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = (HOLD_TO > 1) ? $clog2(HOLD_TO) : 1;
  uart_arb_state_t state, nxt;
  logic [NREQ-1:0] grant_q, ready;
  logic [PW-1:0] rr_ptr, gidx, win, sel;
  logic [CW-1:0] hold_cnt;
  logic [DBIT-1:0] din_q;
  logic last_r, any_valid, accept, release_g, hold_to, to_q, expire;
  uart_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .valid(bus.req_valid),
    .ptr(rr_ptr),
    .win(win),
    .any_valid(any_valid)
  );
  assign expire = hold_cnt == CW'(HOLD_TO - 1);
  always_comb begin
    nxt = state;
    ready = '0;
    accept = 1'b0;
    release_g = 1'b0;
    hold_to = 1'b0;
    sel = win;
    case (state)
      IDLE: begin
        ready = any_valid ? NREQ'(1) << win : '0;
        accept = any_valid;
        nxt = any_valid ? START : IDLE;
      end
      START: nxt = SEND;
      SEND: if (bus.tx_done_tick) begin
        nxt = last_r ? IDLE : HOLD;
        release_g = last_r;
      end
      HOLD: begin
        // a byte arriving on the expiry cycle wins over the timeout
        ready = grant_q;
        sel = gidx;
        accept = bus.req_valid[gidx];
        hold_to = !accept && expire;
        release_g = hold_to;
        nxt = accept ? START : hold_to ? IDLE : HOLD;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      gidx <= '0;
      rr_ptr <= '0;
      din_q <= '0;
      last_r <= 1'b0;
      hold_cnt <= '0;
      to_q <= 1'b0;
    end else begin
      to_q <= hold_to;
      hold_cnt <= (state == HOLD) ? hold_cnt + CW'(1) : '0;
      if (accept) begin
        grant_q <= NREQ'(1) << sel;
        gidx <= sel;
        din_q <= bus.req_data[sel*DBIT +: DBIT];
        last_r <= bus.req_last[sel];
      end
      if (release_g) begin
        grant_q <= '0;
        rr_ptr <= PW'(rr_next(int'(gidx), NREQ));
      end
    end
  end
  assign bus.req_ready = ready;
  assign bus.tx_start = state == START;
  assign bus.tx_din = din_q;
  assign bus.grant = grant_q;
  assign bus.busy = state != IDLE;
  assign bus.timeout_pulse = to_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed and randomized checks of uart_tx_arb against a transaction-level model
module tb_uart_tx_arb;
  localparam int N = 4, W = 8, HT = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_tx_arb_if #(.NREQ(N), .DBIT(W)) bus();
  uart_tx_arb #(.NREQ(N), .DBIT(W), .HOLD_TO(HT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  logic [8:0] q[N][$];
  int vecs = 0, errs = 0;
  int m_ptr, m_owner, m_idle, ser_cnt, vrate = 10;
  bit m_start, m_send, m_locked, m_last, exp_start, exp_to, spur;
  logic [W-1:0] exp_din;
  int log_own[$];
  logic [W-1:0] log_dat[$];
  int n_start, n_sdone, n_to;
  int ord_rr[5] = '{0, 1, 2, 3, 0};
  int ord_lk[4] = '{2, 2, 2, 0};
  logic [W-1:0] dat_lk[4] = '{8'h10, 8'h20, 8'h30, 8'h55};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  function automatic bit pending();
    if (m_owner >= 0 || ser_cnt > 0) return 1;
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1;
    return 0;
  endfunction
  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_idle = 0; ser_cnt = 0;
    m_start = 0; m_send = 0; m_locked = 0; m_last = 0;
    exp_start = 0; exp_to = 0; exp_din = '0; spur = 0;
  endtask
  task automatic step();
    logic [N-1:0] v, er, eg;
    logic [8:0] e;
    bit done;
    int w;
    @(negedge clk);
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("tx_start", bus.tx_start, exp_start);
    chk("tx_din", bus.tx_din, exp_din);
    chk("grant", bus.grant, eg);
    chk("busy", bus.busy, m_owner >= 0);
    chk("timeout_pulse", bus.timeout_pulse, exp_to);
    n_start += bus.tx_start;
    n_to += bus.timeout_pulse;
    if (exp_start) ser_cnt = $urandom_range(2, 5);
    done = spur;
    spur = 0;
    if (ser_cnt > 0) begin
      ser_cnt--;
      if (ser_cnt == 0) begin done = 1; n_sdone++; end
    end
    for (int i = 0; i < N; i++) begin
      v[i] = q[i].size() > 0 && $urandom_range(1, 10) <= vrate;
      e = v[i] ? q[i][0] : 9'($urandom);
      bus.req_valid[i] = v[i];
      bus.req_last[i] = e[8];
      bus.req_data[i*W +: W] = e[7:0];
    end
    bus.tx_done_tick = done;
    #1;
    exp_start = 0;
    exp_to = 0;
    w = -1;
    if (m_owner < 0) w = pick(v);
    else if (m_locked && v[m_owner]) w = m_owner;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    else if (m_locked) er[m_owner] = 1'b1;
    chk("req_ready", bus.req_ready, er);
    if (m_send && done) begin
      m_send = 0;
      if (m_last) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
      else begin m_locked = 1; m_idle = 0; end
    end else if (m_start) begin
      m_start = 0; m_send = 1;
    end else if (w >= 0) begin
      e = q[w].pop_front();
      exp_din = e[7:0]; m_last = e[8]; m_owner = w; m_locked = 0;
      m_start = 1; exp_start = 1;
      log_own.push_back(w); log_dat.push_back(e[7:0]);
    end else if (m_locked) begin
      if (m_idle == HT - 1) begin
        exp_to = 1; m_locked = 0; m_ptr = (m_owner + 1) % N; m_owner = -1;
      end else m_idle++;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_din", bus.tx_din, 0);
    chk("rst_timeout", bus.timeout_pulse, 0);
    for (int i = 0; i < N; i++) q[i].delete();
    bus.req_valid = '0;
    bus.tx_done_tick = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic drain(input int maxc);
    int c = 0;
    while (c < maxc && pending()) begin step(); c++; end
    chk("drain_bound", c < maxc, 1);
    step();
  endtask
  initial begin
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.tx_done_tick = 1'b0;
    model_reset();
    do_reset();
    step();
    chk("idle_ready", bus.req_ready, 0);
    q[1].push_back({1'b1, 8'hA5});
    drain(100);
    chk("single_count", log_own.size(), 1);
    chk("single_owner", log_own[0], 1);
    chk("single_data", log_dat[0], 8'hA5);
    do_reset();
    log_own.delete(); log_dat.delete(); n_start = 0; n_sdone = 0;
    for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'(i + 1)});
    q[0].push_back({1'b1, 8'h50});
    drain(300);
    for (int k = 0; k < 5; k++) chk("rr_order", log_own[k], ord_rr[k]);
    chk("rr_starts", n_start, 5);
    chk("rr_dones", n_sdone, 5);
    do_reset();
    log_own.delete(); log_dat.delete();
    q[2].push_back({1'b0, 8'h10}); q[2].push_back({1'b0, 8'h20}); q[2].push_back({1'b1, 8'h30});
    step();
    q[0].push_back({1'b1, 8'h55});
    drain(300);
    for (int k = 0; k < 4; k++) begin
      chk("lock_owner", log_own[k], ord_lk[k]);
      chk("lock_data", log_dat[k], dat_lk[k]);
    end
    do_reset();
    log_own.delete(); log_dat.delete(); n_to = 0;
    spur = 1;
    step();
    q[3].push_back({1'b0, 8'h77});
    for (int c = 0; c < 20 && !m_locked; c++) step();
    spur = 1;
    step();
    drain(100);
    chk("timeout_count", n_to, 1);
    q[2].push_back({1'b1, 8'h22}); q[0].push_back({1'b1, 8'h00});
    drain(100);
    chk("after_to_owner", log_own[1], 0);
    q[1].push_back({1'b1, 8'h99});
    for (int c = 0; c < 20 && !m_send; c++) step();
    step();
    do_reset();
    spur = 1;
    step();
    step();
    chk("late_tick_busy", bus.busy, 0);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 14) == 0) begin
        int r = $urandom_range(0, N - 1), len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) q[r].push_back({j == len - 1, 8'($urandom)});
      end
      if ($urandom_range(0, 99) == 0) vrate = $urandom_range(5, 10);
      spur = $urandom_range(0, 49) == 0;
      step();
    end
    drain(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
